// File: rtl/fbc_pkg.sv
// fbc_pkg: shared types and constants for the frame buffer controller
package fbc_pkg;
  typedef enum logic {FILL, FULL} state_t;
  localparam int RD_LAT = 2;
endpackage

// File: rtl/fbc_if.sv
// fbc_if: write stream, random read port and frame status of the frame buffer
interface fbc_if #(parameter int DATA_W = 24, parameter int ADDR_W = 14);
  logic i_clear;
  logic i_wr_valid;
  logic o_wr_ready;
  logic [DATA_W-1:0] i_wr_data;
  logic i_rd_valid;
  logic o_rd_ready;
  logic [ADDR_W-1:0] i_rd_addr;
  logic o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic o_rd_err;
  logic [ADDR_W:0] o_wr_count;
  logic o_frame_done;
  logic [7:0] o_frame_cnt;
  modport master(
    output i_clear, i_wr_valid, i_wr_data, i_rd_valid, i_rd_addr,
    input o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_rd_err, o_wr_count, o_frame_done, o_frame_cnt
  );
  modport slave(
    input i_clear, i_wr_valid, i_wr_data, i_rd_valid, i_rd_addr,
    output o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_rd_err, o_wr_count, o_frame_done, o_frame_cnt
  );
endinterface

// File: rtl/fbc_ram.sv
// fbc_ram: single-port synchronous RAM with registered read, contents never reset
module fbc_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 14,
  parameter int DEPTH = 16384
) (
  input  logic i_clk,
  input  logic i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr[AW-1:0]] <= i_wdata;
    o_rdata <= mem[i_addr[AW-1:0]];
  end
endmodule

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: streams pixels into a frame RAM and serves fixed-latency random reads
module frame_buffer_ctrl
  import fbc_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 14,
  parameter int DEPTH = 16384,
  parameter int WRAP_MODE = 0
) (
  input logic i_clk,
  input logic i_rst_n,
  fbc_if.slave bus
);
  state_t state, state_nx;
  logic wr_ready, wr_en, rd_en, rd_oob, last;
  logic [ADDR_W-1:0] wr_ptr, ram_addr;
  logic [ADDR_W:0] wr_count;
  logic frame_done;
  logic [7:0] frame_cnt;
  logic [RD_LAT-1:0] vld_sr, err_sr;
  logic [DATA_W-1:0] ram_q, rd_data;
  assign wr_en = bus.i_wr_valid && wr_ready;
  assign rd_en = bus.i_rd_valid && !wr_en;
  assign rd_oob = {1'b0, bus.i_rd_addr} >= (ADDR_W+1)'(DEPTH);
  assign last = wr_en && wr_ptr == ADDR_W'(DEPTH - 1);
  assign ram_addr = wr_en ? wr_ptr : bus.i_rd_addr;
  always_comb begin
    wr_ready = state == FILL && !bus.i_clear;
    state_nx = bus.i_clear ? FILL : (last && WRAP_MODE == 0) ? FULL : state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= FILL;
    else state <= state_nx;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      wr_count <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_done <= last;
      if (last) frame_cnt <= frame_cnt + 8'd1;
      if (bus.i_clear) begin
        wr_ptr <= '0;
        wr_count <= '0;
      end else if (wr_en) begin
        wr_ptr <= last ? '0 : wr_ptr + ADDR_W'(1);
        wr_count <= (last && WRAP_MODE != 0) ? '0 : wr_count + (ADDR_W+1)'(1);
      end
    end
  fbc_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .i_clk(i_clk),
    .i_we(wr_en),
    .i_addr(ram_addr),
    .i_wdata(bus.i_wr_data),
    .o_rdata(ram_q)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      vld_sr <= '0;
      err_sr <= '0;
      rd_data <= '0;
    end else begin
      vld_sr <= {vld_sr[RD_LAT-2:0], rd_en};
      err_sr <= {err_sr[RD_LAT-2:0], rd_en && rd_oob};
      rd_data <= (vld_sr[0] && !err_sr[0]) ? ram_q : '0;
    end
  assign bus.o_wr_ready = wr_ready;
  assign bus.o_rd_ready = !wr_en;
  assign bus.o_rd_valid = vld_sr[RD_LAT-1];
  assign bus.o_rd_err = err_sr[RD_LAT-1];
  assign bus.o_rd_data = rd_data;
  assign bus.o_wr_count = wr_count;
  assign bus.o_frame_done = frame_done;
  assign bus.o_frame_cnt = frame_cnt;
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: stop and wrap instances driven together against a cycle-level reference model
module tb_frame_buffer_ctrl;
  localparam int DEPTH = 16;
  typedef struct {
    int due;
    logic [23:0] d;
    logic e;
  } rd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0, wr_valid = 1'b0, rd_valid = 1'b0;
  logic [23:0] wr_data = '0;
  logic [4:0] rd_addr = '0;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [23:0] mem [2][DEPTH];
  int ptr [2], cnt [2], fcnt [2];
  bit full [2], done [2];
  rd_t rq [2][$];
  fbc_if #(.DATA_W(24), .ADDR_W(5)) b0 ();
  fbc_if #(.DATA_W(24), .ADDR_W(5)) b1 ();
  assign b0.i_clear = clear;
  assign b0.i_wr_valid = wr_valid;
  assign b0.i_wr_data = wr_data;
  assign b0.i_rd_valid = rd_valid;
  assign b0.i_rd_addr = rd_addr;
  assign b1.i_clear = clear;
  assign b1.i_wr_valid = wr_valid;
  assign b1.i_wr_data = wr_data;
  assign b1.i_rd_valid = rd_valid;
  assign b1.i_rd_addr = rd_addr;
  frame_buffer_ctrl #(.DATA_W(24), .ADDR_W(5), .DEPTH(DEPTH), .WRAP_MODE(0)) u_stop (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave)
  );
  frame_buffer_ctrl #(.DATA_W(24), .ADDR_W(5), .DEPTH(DEPTH), .WRAP_MODE(1)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic inst(input int k, input logic wrdy, input logic rrdy, input logic rv, input logic re,
                      input logic [23:0] rd, input logic [5:0] wc, input logic fd, input logic [7:0] fc);
    bit wacc, racc, ev;
    int a;
    rd_t e;
    wacc = wr_valid && !full[k] && !clear;
    racc = rd_valid && !wacc;
    ev = rq[k].size() > 0 && rq[k][0].due == cyc;
    chk($sformatf("wr_ready[%0d]", k), wrdy, !full[k] && !clear);
    chk($sformatf("rd_ready[%0d]", k), rrdy, !wacc);
    chk($sformatf("rd_valid[%0d]", k), rv, ev);
    if (ev) begin
      e = rq[k].pop_front();
      chk($sformatf("rd_data[%0d]", k), rd, e.d);
      chk($sformatf("rd_err[%0d]", k), re, e.e);
    end
    chk($sformatf("wr_count[%0d]", k), wc, cnt[k]);
    chk($sformatf("frame_done[%0d]", k), fd, done[k]);
    chk($sformatf("frame_cnt[%0d]", k), fc, fcnt[k]);
    done[k] = 0;
    if (clear) begin
      ptr[k] = 0;
      cnt[k] = 0;
      full[k] = 0;
    end else if (wacc) begin
      mem[k][ptr[k]] = wr_data;
      cnt[k]++;
      if (ptr[k] == DEPTH - 1) begin
        ptr[k] = 0;
        done[k] = 1;
        fcnt[k] = (fcnt[k] + 1) % 256;
        if (k == 1) cnt[k] = 0;
        else full[k] = 1;
      end else ptr[k]++;
    end
    if (racc) begin
      a = int'(rd_addr);
      rq[k].push_back('{cyc + 2, (a < DEPTH) ? mem[k][a] : 24'd0, a >= DEPTH});
    end
  endtask
  task automatic step(input logic c, input logic wv, input logic [23:0] wd, input logic rv, input logic [4:0] ra);
    clear = c;
    wr_valid = wv;
    wr_data = wd;
    rd_valid = rv;
    rd_addr = ra;
    #1;
    inst(0, b0.o_wr_ready, b0.o_rd_ready, b0.o_rd_valid, b0.o_rd_err, b0.o_rd_data, b0.o_wr_count, b0.o_frame_done, b0.o_frame_cnt);
    inst(1, b1.o_wr_ready, b1.o_rd_ready, b1.o_rd_valid, b1.o_rd_err, b1.o_rd_data, b1.o_wr_count, b1.o_frame_done, b1.o_frame_cnt);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic rst_chk(input int k, input logic wrdy, input logic rrdy, input logic rv, input logic re,
                         input logic [23:0] rd, input logic [5:0] wc, input logic fd, input logic [7:0] fc);
    chk($sformatf("rst_wr_ready[%0d]", k), wrdy, 1);
    chk($sformatf("rst_rd_ready[%0d]", k), rrdy, 1);
    chk($sformatf("rst_rd_valid[%0d]", k), rv, 0);
    chk($sformatf("rst_rd_err[%0d]", k), re, 0);
    chk($sformatf("rst_rd_data[%0d]", k), rd, 0);
    chk($sformatf("rst_wr_count[%0d]", k), wc, 0);
    chk($sformatf("rst_frame_done[%0d]", k), fd, 0);
    chk($sformatf("rst_frame_cnt[%0d]", k), fc, 0);
  endtask
  task automatic do_reset();
    clear = 0;
    wr_valid = 0;
    rd_valid = 0;
    wr_data = '0;
    rd_addr = '0;
    rst_n = 0;
    #1;
    rst_chk(0, b0.o_wr_ready, b0.o_rd_ready, b0.o_rd_valid, b0.o_rd_err, b0.o_rd_data, b0.o_wr_count, b0.o_frame_done, b0.o_frame_cnt);
    rst_chk(1, b1.o_wr_ready, b1.o_rd_ready, b1.o_rd_valid, b1.o_rd_err, b1.o_rd_data, b1.o_wr_count, b1.o_frame_done, b1.o_frame_cnt);
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 0;
      cnt[k] = 0;
      fcnt[k] = 0;
      full[k] = 0;
      done[k] = 0;
      rq[k].delete();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 16; i++) step(0, 1, 24'(i), 0, 5'd0);
    step(0, 0, 24'd0, 0, 5'd0);
    chk("fill_count", b0.o_wr_count, 16);
    chk("fill_frames", b0.o_frame_cnt, 1);
    chk("fill_wr_ready", b0.o_wr_ready, 0);
    step(0, 1, 24'd17, 0, 5'd0);
    chk("no_17th_write", b0.o_wr_count, 16);
    for (int i = 0; i < 16; i++) step(0, 0, 24'd0, 1, 5'(i));
    repeat (3) step(0, 0, 24'd0, 0, 5'd0);
    do_reset();
    for (int i = 0; i < 40; i++) step(0, 1, 24'(i), 0, 5'd0);
    step(0, 0, 24'd0, 0, 5'd0);
    chk("wrap_frames", b1.o_frame_cnt, 2);
    chk("wrap_count", b1.o_wr_count, 8);
    step(0, 0, 24'd0, 1, 5'd3);
    step(0, 0, 24'd0, 0, 5'd0);
    chk("wrap_rd_addr3", b1.o_rd_data, 35);
    step(0, 0, 24'd0, 0, 5'd0);
    step(1, 1, 24'hAA, 0, 5'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 24'(100 + i), 1, 5'd5);
    step(0, 0, 24'd0, 1, 5'd5);
    repeat (3) step(0, 0, 24'd0, 0, 5'd0);
    step(0, 0, 24'd0, 1, 5'd20);
    step(0, 0, 24'd0, 0, 5'd0);
    chk("oob_valid", b0.o_rd_valid, 1);
    chk("oob_err", b0.o_rd_err, 1);
    chk("oob_data", b0.o_rd_data, 0);
    step(0, 0, 24'd0, 0, 5'd0);
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 24'(24'h500 + i), 0, 5'd0);
    step(1, 1, 24'h777, 0, 5'd0);
    chk("clear_count", b0.o_wr_count, 0);
    step(0, 1, 24'h888, 0, 5'd0);
    step(0, 0, 24'd0, 1, 5'd0);
    step(0, 0, 24'd0, 0, 5'd0);
    chk("clear_addr0", b0.o_rd_data, 24'h888);
    step(0, 0, 24'd0, 0, 5'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(31) == 0, 1'($urandom), 24'($urandom), 1'($urandom), 5'($urandom_range(31)));
    repeat (3) step(0, 0, 24'd0, 0, 5'd0);
    step(0, 0, 24'd0, 1, 5'd1);
    step(0, 0, 24'd0, 1, 5'd2);
    do_reset();
    repeat (4) step(0, 0, 24'd0, 0, 5'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
